// File: rtl/gate_controller_if.sv
// Parking-gate signal bundle: slow divider clocks and car requests in, gate/lot status out.
interface gate_controller_if #(
  parameter int CNT_W = 4
);
  logic             clk_1Hz;
  logic             clk_2Hz;
  logic             entry_req;
  logic             exit_req;
  logic             pass_sensor;
  logic             gate_open;
  logic             warn_led;
  logic             denied;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] free_slots;
  logic             full;

  modport master (
    output clk_1Hz, clk_2Hz, entry_req, exit_req, pass_sensor,
    input  gate_open, warn_led, denied, occupancy, free_slots, full
  );

  modport slave (
    input  clk_1Hz, clk_2Hz, entry_req, exit_req, pass_sensor,
    output gate_open, warn_led, denied, occupancy, free_slots, full
  );
endinterface

// File: rtl/gate_controller.sv
// Entry/exit gate sequencer: open, wait for car or timeout, blink warning, close.
// Tracks lot occupancy and refuses entry while the lot is full.
module gate_controller #(
  parameter int CAPACITY  = 8,
  parameter int CNT_W     = 4,
  parameter int OPEN_SECS = 10,
  parameter int WARN_SECS = 3
) (
  input logic          clk,
  input logic          reset,
  gate_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    EXIT  = 2'd2,
    WARN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CAP    = CNT_W'(CAPACITY);
  localparam logic [7:0]       OPEN_T = 8'(OPEN_SECS);
  localparam logic [7:0]       WARN_T = 8'(WARN_SECS);

  state_t           state, state_n;
  logic [7:0]       timer, timer_n;
  logic [CNT_W-1:0] occupancy;
  logic             c1_q, c2_q;
  logic             tick1, tick2;
  logic             is_full, exit_go, entry_go;
  logic             occ_inc, occ_dec;
  logic             gate_n, warn_n, deny_n;
  logic             gate_q, warn_q, deny_q, deny_lock;

  assign tick1    = bus.clk_1Hz & ~c1_q;
  assign tick2    = bus.clk_2Hz & ~c2_q;
  assign is_full  = (occupancy == CAP);
  assign exit_go  = bus.exit_req && (occupancy != '0);
  assign entry_go = bus.entry_req && !is_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    occ_inc = 1'b0;
    occ_dec = 1'b0;
    unique case (state)
      IDLE: begin
        // exit is checked first so a departing car frees a slot before entry is judged
        if (exit_go) begin
          state_n = EXIT;
          timer_n = OPEN_T;
        end else if (entry_go) begin
          state_n = ENTRY;
          timer_n = OPEN_T;
        end
      end
      ENTRY, EXIT: begin
        if (bus.pass_sensor) begin
          state_n = WARN;
          timer_n = WARN_T;
          occ_inc = (state == ENTRY);
          occ_dec = (state == EXIT);
        end else if (tick1) begin
          if (timer == 8'd1) begin
            state_n = WARN;
            timer_n = WARN_T;
          end else begin
            timer_n = timer - 8'd1;
          end
        end
      end
      WARN: begin
        // a car under the beam restarts the warning so the gate never drops on it
        if (bus.pass_sensor) begin
          timer_n = WARN_T;
        end else if (tick1) begin
          if (timer == 8'd1) state_n = IDLE;
          else               timer_n = timer - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gate_n = (state != IDLE);
    warn_n = (state == WARN) ? (warn_q ^ tick2) : 1'b0;
    deny_n = (state == IDLE) && bus.entry_req && is_full && !exit_go && !deny_lock;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      occupancy <= '0;
      c1_q      <= 1'b0;
      c2_q      <= 1'b0;
      gate_q    <= 1'b0;
      warn_q    <= 1'b0;
      deny_q    <= 1'b0;
      deny_lock <= 1'b0;
    end else begin
      timer  <= timer_n;
      c1_q   <= bus.clk_1Hz;
      c2_q   <= bus.clk_2Hz;
      gate_q <= gate_n;
      warn_q <= warn_n;
      deny_q <= deny_n;
      // one refusal per request; cleared once the driver lets go of entry_req
      deny_lock <= bus.entry_req & (deny_lock | deny_n);
      if (occ_inc && occupancy != CAP)
        occupancy <= occupancy + 1'b1;
      else if (occ_dec && occupancy != '0)
        occupancy <= occupancy - 1'b1;
    end
  end

  assign bus.gate_open  = gate_q;
  assign bus.warn_led   = warn_q;
  assign bus.denied     = deny_q;
  assign bus.occupancy  = occupancy;
  assign bus.free_slots = CAP - occupancy;
  assign bus.full       = is_full;

endmodule

// File: tb/tb_gate_controller.sv
// Bench for gate_controller: transaction table, multi-cycle corner sequences and a
// random phase, all compared each cycle against a seconds-level behavioural model.
module tb_gate_controller;
  localparam int CAPACITY  = 8;
  localparam int CNT_W     = 4;
  localparam int OPEN_SECS = 10;
  localparam int WARN_SECS = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   t1_pend = 0;
  bit   chk_en = 0;

  gate_controller_if #(.CNT_W(CNT_W)) b();

  gate_controller #(
    .CAPACITY(CAPACITY), .CNT_W(CNT_W), .OPEN_SECS(OPEN_SECS), .WARN_SECS(WARN_SECS)
  ) dut (
    .clk(clk), .reset(reset), .bus(b)
  );

  always #5 clk = ~clk;

  // slow square waves, 40/20 clk periods; t1_pend flags that the next edge sees a 1Hz rise
  initial begin
    b.clk_1Hz = 1'b0;
    b.clk_2Hz = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      t1_pend   = ((cyc % 40) >= 20) && !b.clk_1Hz;
      b.clk_1Hz = ((cyc % 40) >= 20);
      b.clk_2Hz = ((cyc % 20) >= 10);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  // mode: 0 idle, 1 admitting, 2 releasing, 3 warning; secs = seconds left in the phase
  typedef struct {
    int mode;
    int secs;
    int occ;
    bit gate, warn, den, lock, p1, p2;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_next(mdl_t cur, bit c1, bit c2, bit ent, bit ext, bit ps);
    mdl_t n;
    bit t1, t2;
    n  = cur;
    t1 = c1 && !cur.p1;
    t2 = c2 && !cur.p2;
    n.p1   = c1;
    n.p2   = c2;
    n.gate = (cur.mode != 0);
    n.warn = (cur.mode == 3) ? (t2 ? !cur.warn : cur.warn) : 1'b0;
    n.den  = 1'b0;
    if (!ent) n.lock = 1'b0;
    case (cur.mode)
      0: begin
        if (ext && cur.occ > 0) begin
          n.mode = 2; n.secs = OPEN_SECS;
        end else if (ent && cur.occ < CAPACITY) begin
          n.mode = 1; n.secs = OPEN_SECS;
        end else if (ent && !cur.lock) begin
          n.den = 1'b1; n.lock = 1'b1;
        end
      end
      1, 2: begin
        if (ps) begin
          if (cur.mode == 1) n.occ = (cur.occ < CAPACITY) ? cur.occ + 1 : CAPACITY;
          else               n.occ = (cur.occ > 0) ? cur.occ - 1 : 0;
          n.mode = 3; n.secs = WARN_SECS;
        end else if (t1) begin
          if (cur.secs <= 1) begin n.mode = 3; n.secs = WARN_SECS; end
          else n.secs = cur.secs - 1;
        end
      end
      default: begin
        if (ps) n.secs = WARN_SECS;
        else if (t1) begin
          if (cur.secs <= 1) n.mode = 0;
          else n.secs = cur.secs - 1;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{default: 0};
    else       m <= mdl_next(m, b.clk_1Hz, b.clk_2Hz, b.entry_req, b.exit_req, b.pass_sensor);
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // every bench wait goes through here, so the model is compared on every cycle
  task automatic step();
    logic [11:0] act, exp_v;
    @(negedge clk);
    if (chk_en) begin
      act   = {b.gate_open, b.warn_led, b.denied, b.occupancy, b.free_slots, b.full};
      exp_v = {m.gate, m.warn, m.den, 4'(m.occ), 4'(CAPACITY - m.occ), (m.occ == CAPACITY)};
      n_chk++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL model_cmp t=%0t got g%0b w%0b d%0b occ%0d free%0d full%0b expected g%0b w%0b d%0b occ%0d free%0d full%0b",
                 $time, act[11], act[10], act[9], act[8:5], act[4:1], act[0],
                 exp_v[11], exp_v[10], exp_v[9], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
  endtask

  task automatic wait_ticks(input int n);
    int cnt = 0;
    for (int i = 0; i < n * 60 && cnt < n; i++) begin
      step();
      if (t1_pend) cnt++;
    end
    chk("wait_ticks", cnt, n);
  endtask

  task automatic align();
    for (int i = 0; i < 100 && !t1_pend; i++) step();
    chk("align", int'(t1_pend), 1);
  endtask

  task automatic wait_gate_open();
    for (int i = 0; i < 8 && !b.gate_open; i++) step();
    chk("gate_rise", int'(b.gate_open), 1);
  endtask

  task automatic txn(input bit ent, input bit ext, input bit ps, output bit opened, output bit den);
    opened = 0;
    den    = 0;
    b.entry_req = ent;
    b.exit_req  = ext;
    for (int i = 0; i < 4 && !opened; i++) begin
      step();
      if (b.denied)    den = 1;
      if (b.gate_open) opened = 1;
    end
    b.entry_req = 0;
    b.exit_req  = 0;
    if (opened) begin
      if (ps) begin
        wait_ticks(2);
        step();
        b.pass_sensor = 1;
        step();
        b.pass_sensor = 0;
      end
      for (int i = 0; i < 1200 && b.gate_open; i++) step();
      chk("txn_close", int'(b.gate_open), 0);
    end
  endtask

  typedef struct {
    bit ent, ext, ps;
    int occ;
    bit full;
    int free;
    bit opened, den;
  } vec_t;

  initial begin
    vec_t tbl[$];
    bit   op, dn, pw;
    int   cnt, rises, lows, rst_at;

    for (int k = 1; k <= CAPACITY; k++)
      tbl.push_back('{1, 0, 1, k, (k == CAPACITY), CAPACITY - k, 1, 0});
    tbl.push_back('{1, 0, 1, 8, 1, 0, 0, 1});   // full lot: refused
    tbl.push_back('{0, 1, 1, 7, 0, 1, 1, 0});   // a car leaves
    tbl.push_back('{1, 0, 0, 7, 0, 1, 1, 0});   // entry timeout
    tbl.push_back('{0, 1, 0, 7, 0, 1, 1, 0});   // exit timeout

    b.entry_req   = 0;
    b.exit_req    = 0;
    b.pass_sensor = 0;
    chk_en        = 1;

    repeat (3) step();
    chk("rst_gate", int'(b.gate_open), 0);
    chk("rst_warn", int'(b.warn_led), 0);
    chk("rst_denied", int'(b.denied), 0);
    chk("rst_occ", int'(b.occupancy), 0);
    chk("rst_free", int'(b.free_slots), CAPACITY);
    chk("rst_full", int'(b.full), 0);
    reset = 0;
    repeat (3) step();

    foreach (tbl[i]) begin
      txn(tbl[i].ent, tbl[i].ext, tbl[i].ps, op, dn);
      chk($sformatf("tbl%0d_opened", i), int'(op), int'(tbl[i].opened));
      chk($sformatf("tbl%0d_denied", i), int'(dn), int'(tbl[i].den));
      chk($sformatf("tbl%0d_occ", i), int'(b.occupancy), tbl[i].occ);
      chk($sformatf("tbl%0d_full", i), int'(b.full), int'(tbl[i].full));
      chk($sformatf("tbl%0d_free", i), int'(b.free_slots), tbl[i].free);
      repeat (3) step();
    end

    // drain to 2, then both requests together: exit must win
    for (int i = 0; i < 5; i++) begin
      txn(0, 1, 1, op, dn);
      repeat (3) step();
    end
    chk("drain_occ", int'(b.occupancy), 2);
    txn(1, 1, 1, op, dn);
    chk("simul_opened", int'(op), 1);
    chk("simul_occ", int'(b.occupancy), 1);
    repeat (3) step();

    // entry with pass: three warning seconds, three led blinks
    align();
    b.entry_req = 1;
    wait_gate_open();
    b.entry_req = 0;
    wait_ticks(2);
    step();
    b.pass_sensor = 1;
    step();
    b.pass_sensor = 0;
    cnt = 0; rises = 0; pw = b.warn_led;
    for (int i = 0; i < 1000 && b.gate_open; i++) begin
      step();
      if (t1_pend && b.gate_open) cnt++;
      if (b.warn_led && !pw) rises++;
      pw = b.warn_led;
    end
    chk("entry_warn_ticks", cnt, WARN_SECS);
    chk("entry_warn_blinks", rises, WARN_SECS);
    chk("entry_occ", int'(b.occupancy), 2);
    repeat (3) step();

    // no car: open for OPEN_SECS, warn for WARN_SECS, count unchanged
    align();
    b.entry_req = 1;
    wait_gate_open();
    b.entry_req = 0;
    cnt = 0; rises = 0; pw = b.warn_led;
    for (int i = 0; i < 1500 && b.gate_open; i++) begin
      if (t1_pend && b.gate_open) cnt++;
      step();
      if (b.warn_led && !pw) rises++;
      pw = b.warn_led;
    end
    chk("timeout_ticks", cnt, OPEN_SECS + WARN_SECS);
    chk("timeout_blinks", rises, WARN_SECS);
    chk("timeout_occ", int'(b.occupancy), 2);
    repeat (3) step();

    // car lingers under the beam during warning
    b.entry_req = 1;
    wait_gate_open();
    b.entry_req   = 0;
    b.pass_sensor = 1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!b.gate_open) lows++;
    end
    chk("safety_gate_held", lows, 0);
    chk("safety_occ", int'(b.occupancy), 3);
    align();
    step();
    b.pass_sensor = 0;
    cnt = 0;
    for (int i = 0; i < 1000 && b.gate_open; i++) begin
      step();
      if (t1_pend && b.gate_open) cnt++;
    end
    chk("safety_close_ticks", cnt, WARN_SECS);
    repeat (3) step();

    // asynchronous reset with the entry timer at 5
    b.entry_req = 1;
    wait_gate_open();
    b.entry_req = 0;
    wait_ticks(OPEN_SECS - 5);
    step();
    chk("pre_rst_gate", int'(b.gate_open), 1);
    #1 reset = 1;
    #1;
    chk("async_rst_gate", int'(b.gate_open), 0);
    chk("async_rst_warn", int'(b.warn_led), 0);
    chk("async_rst_occ", int'(b.occupancy), 0);
    chk("async_rst_free", int'(b.free_slots), CAPACITY);
    step();
    reset = 0;
    repeat (5) step();
    chk("post_rst_gate", int'(b.gate_open), 0);

    // random traffic against the model
    rst_at = $urandom_range(3000, 7000);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        b.entry_req = ($urandom_range(0, 99) < 55);
        b.exit_req  = ($urandom_range(0, 99) < 30);
      end
      b.pass_sensor = ($urandom_range(0, 59) == 0);
      if (i == rst_at)     reset = 1;
      if (i == rst_at + 2) reset = 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
